register_bank_m: RTL and testbench

- General-purpose register file for the 16-bit pipelined processor.
- Two synchronous read ports feed the ALU operands of the decode stage.
- One synchronous write port is driven by the write-back stage.
- Sits inside decode; the write-back address, data and enable arrive from the end of the pipeline.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/register_bank_m_if.sv | 28 ++
 rtl/register_bank_m_reg_read_port.sv | 39 +++
 rtl/register_bank_m.sv | 48 ++++
 tb/tb_register_bank_m.sv | 138 +++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit processor register file.
//   DATA_W   : register width in bits
//   ADDR_W   : register index width
//   NUM_REGS : register count (2**ADDR_W)
//   word_t / reg_addr_t : data word and register index types
package cpu_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/register_bank_m_if.sv
// Register bank access bundle: two read ports plus the write-back port.
//   address_a, address_b : read indices (driven by decode)
//   address_in, data_in, wren : write-back index, data, enable
//   q_a, q_b : registered read data (driven by the bank)
// master = pipeline side, slave = register bank side.
interface register_bank_m_if
  import cpu_pkg::*;
  ();

  reg_addr_t address_a;
  reg_addr_t address_b;
  reg_addr_t address_in;
  word_t     data_in;
  logic      wren;
  word_t     q_a;
  word_t     q_b;

  modport master (
    output address_a, address_b, address_in, data_in, wren,
    input  q_a, q_b
  );

  modport slave (
    input  address_a, address_b, address_in, data_in, wren,
    output q_a, q_b
  );

endinterface

// File: rtl/register_bank_m_reg_read_port.sv
// One synchronous read port of the register bank.
//   clock, reset : clock and async active-high reset (clears q)
//   rd_addr      : register index to read
//   regs         : current contents of the storage array
//   wr_addr, wr_data, wren : same-edge write, used for write-through
//   q            : registered read data, one cycle after rd_addr
module reg_read_port
  import cpu_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  reg_addr_t rd_addr,
  input  word_t     regs [NUM_REGS],
  input  reg_addr_t wr_addr,
  input  word_t     wr_data,
  input  logic      wren,
  output word_t     q
);

  word_t rd_data;

  // A write landing on the register being read this edge wins over the
  // stale array value, so the consumer never sees old data.
  always_comb begin
    rd_data = regs[rd_addr];
    if (wren && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= rd_data;
    end
  end

endmodule

// File: rtl/register_bank_m.sv
// General-purpose register file: 16 x 16-bit, two registered read ports,
// one write port with write-through bypass to both read ports.
//   clock : system clock, rising edge
//   reset : async active-high; clears all registers and both outputs
//   bus   : register_bank_m_if slave (addresses, write data/enable, q_a/q_b)
module register_bank_m
  import cpu_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  register_bank_m_if.slave        bus
);

  word_t regs [NUM_REGS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wren) begin
      regs[bus.address_in] <= bus.data_in;
    end
  end

  reg_read_port u_port_a (
    .clock   (clock),
    .reset   (reset),
    .rd_addr (bus.address_a),
    .regs    (regs),
    .wr_addr (bus.address_in),
    .wr_data (bus.data_in),
    .wren    (bus.wren),
    .q       (bus.q_a)
  );

  reg_read_port u_port_b (
    .clock   (clock),
    .reset   (reset),
    .rd_addr (bus.address_b),
    .regs    (regs),
    .wr_addr (bus.address_in),
    .wr_data (bus.data_in),
    .wren    (bus.wren),
    .q       (bus.q_b)
  );

endmodule

// File: tb/tb_register_bank_m.sv
// Self-checking bench for register_bank_m: directed scenarios followed by
// random traffic, checked against a plain array model of the register file.
module tb_register_bank_m;

  logic clock;
  logic reset;

  register_bank_m_if bus ();

  register_bank_m dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mdl [16];
  logic [15:0] exp_a;
  logic [15:0] exp_b;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [3:0] aa, input logic [3:0] ab,
                       input logic [3:0] ai, input logic [15:0] d, input logic w);
    bus.address_a  = aa;
    bus.address_b  = ab;
    bus.address_in = ai;
    bus.data_in    = d;
    bus.wren       = w;
  endtask

  // Predict the edge from the current inputs, clock it, check both outputs.
  task automatic tick(input string tag);
    if (reset) begin
      for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
      exp_a = 16'h0000;
      exp_b = 16'h0000;
    end else begin
      exp_a = (bus.wren && bus.address_in == bus.address_a) ? bus.data_in : mdl[bus.address_a];
      exp_b = (bus.wren && bus.address_in == bus.address_b) ? bus.data_in : mdl[bus.address_b];
      if (bus.wren) mdl[bus.address_in] = bus.data_in;
    end
    @(posedge clock);
    #1;
    check_val({tag, "_q_a"}, bus.q_a, exp_a);
    check_val({tag, "_q_b"}, bus.q_b, exp_b);
  endtask

  initial begin
    reset = 1'b1;
    drive(4'd0, 4'd0, 4'd0, 16'h0000, 1'b0);
    for (int i = 0; i < 16; i++) mdl[i] = 16'hxxxx;
    tick("init_rst");
    tick("init_rst2");
    reset = 1'b0;

    // Reset state: every register reads zero.
    for (int i = 0; i < 16; i += 2) begin
      drive(4'(i), 4'(i + 1), 4'd0, 16'h0000, 1'b0);
      tick("rst_sweep");
      check_val("rst_sweep_zero_a", bus.q_a, 16'h0000);
      check_val("rst_sweep_zero_b", bus.q_b, 16'h0000);
    end

    // Write then read.
    drive(4'd0, 4'd0, 4'd3, 16'h1234, 1'b1); tick("wr3");
    drive(4'd0, 4'd0, 4'd7, 16'hABCD, 1'b1); tick("wr7");
    drive(4'd3, 4'd7, 4'd0, 16'h0000, 1'b0); tick("rd37");
    check_val("rd3_const", bus.q_a, 16'h1234);
    check_val("rd7_const", bus.q_b, 16'hABCD);

    // Write-enable gating.
    drive(4'd0, 4'd0, 4'd5, 16'hFFFF, 1'b0); tick("nowr5");
    drive(4'd5, 4'd5, 4'd0, 16'h0000, 1'b0); tick("rd5");
    check_val("rd5_const", bus.q_a, 16'h0000);

    // Read-during-write bypass on both ports.
    drive(4'd9, 4'd9, 4'd9, 16'h00AA, 1'b1); tick("byp9");
    check_val("byp9_a_const", bus.q_a, 16'h00AA);
    check_val("byp9_b_const", bus.q_b, 16'h00AA);

    // Full sweep including register 0.
    for (int i = 0; i < 16; i++) begin
      drive(4'd0, 4'd15, 4'(i), 16'h1000 + 16'(i), 1'b1);
      tick("sweep_wr");
    end
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 4'(15 - i), 4'd0, 16'h0000, 1'b0);
      tick("sweep_rd");
      check_val("sweep_a_const", bus.q_a, 16'h1000 + 16'(i));
      check_val("sweep_b_const", bus.q_b, 16'h1000 + 16'(15 - i));
    end

    // Reset after data loaded, asserted mid-cycle, with a write attempted.
    drive(4'd0, 4'd0, 4'd2, 16'h5555, 1'b1); tick("wr2");
    drive(4'd2, 4'd2, 4'd2, 16'h7777, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_val("rst_async_a", bus.q_a, 16'h0000);
    check_val("rst_async_b", bus.q_b, 16'h0000);
    tick("rst_wr_blocked");
    reset = 1'b0;
    drive(4'd2, 4'd2, 4'd0, 16'h0000, 1'b0); tick("rd2_after_rst");
    check_val("rd2_after_rst_const", bus.q_a, 16'h0000);
    // First write after release takes effect.
    drive(4'd2, 4'd0, 4'd2, 16'h3C3C, 1'b1); tick("wr2_after_rst");
    check_val("wr2_after_rst_const", bus.q_a, 16'h3C3C);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      drive(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
            16'($urandom), 1'($urandom_range(1)));
      if ($urandom_range(63) == 0) begin
        reset = 1'b1;
        tick("rand_rst");
        reset = 1'b0;
      end else begin
        tick("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
